asic_event_framer: RTL
======================

// Module: asic_event_framer
// PURPOSE
//  Downstream of the ASIC RAM readout stage. Buffers the 16-bit words it produces (DataInValid strobes) for one readout.
//  On the ReadDone pulse, emits one framed event toward the USB/external FIFO over a valid/ready handshake.
//  Frame layout: header, status, word count, payload, XOR checksum, trailer.
//  Decouples the readout stage, which has no backpressure, from the stallable output path.
// PARAMETERS
//  ADDR_WIDTH    8         buffer depth = 2**ADDR_WIDTH words (256)
//  HEADER_WORD   16'hFFFC  first word of every frame
//  TRAILER_WORD  16'hFF45  last word of every frame
// PORTS
//  Clk          in   1   single clock; all logic on posedge
//  Reset        in   1   synchronous, active-high reset
//  ChipId       in   8   ASIC identifier; sampled with ReadDone
//  DataIn       in   16  readout word
//  DataInValid  in   1   DataIn valid this cycle; no backpressure upstream
//  ReadDone     in   1   one-cycle pulse: current readout complete
//  OutData      out  16  frame word
//  OutValid     out  1   OutData valid
//  OutReady     in   1   sink accepts; transfer = OutValid & OutReady
//  FrameDone    out  1   one-cycle pulse, cycle after trailer transfer
//  Overflow     out  1   sticky: input word dropped on full buffer
//  EventLost    out  1   sticky: ReadDone arrived with one already pending (events merged)
//  Busy         out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, buffer pointers 0, event accumulators 0, pending flag 0, state IDLE. Applies mid-frame: frame aborted, buffer flushed.
//  Buffer: synchronous FIFO, 2**ADDR_WIDTH x 16.
//   - Write when DataInValid & !full. full/empty from registered pointers only; a same-cycle read does not free space.
//   - DataInValid while full: word dropped, Overflow<=1, event ovf bit set.
//  Per-event accumulators (ADDR_WIDTH+1 bit count; 16-bit XOR):
//   - count += 1 and chk ^= DataIn for each stored word; dropped words are not counted.
//   - DataInValid and ReadDone in the same cycle: that word belongs to the closing event.
//  On ReadDone: latch {ChipId, ovf, count, chk} into the pending slot, set pending, clear accumulators for the next event.
//   - ReadDone while pending already set: EventLost<=1; add the new count into the pending count, XOR the new chk in, OR ovf. Payloads are contiguous in the buffer, so the merged frame stays consistent.
//  FSM (one word per state except PAYLOAD; advance only on transfer):
//   IDLE -> HEADER when pending; takes the pending slot into frame regs, clears pending.
//     OutValid rises the cycle after ReadDone is registered.
//   HEADER   OutData=HEADER_WORD                    -> STATUS
//   STATUS   OutData={ovf,7'b0,ChipId}               -> COUNT
//   COUNT    OutData=zero-extended count            -> PAYLOAD, or CHECKSUM if count==0
//   PAYLOAD  OutData=buffer head; pop on transfer, decrement remaining -> CHECKSUM after last word
//   CHECKSUM OutData=chk                            -> TRAILER
//   TRAILER  OutData=TRAILER_WORD; on transfer pulse FrameDone next cycle.
//     Next state is HEADER if pending is set at that time, else IDLE.
//  Handshake:
//   - OutData and OutValid hold stable while OutValid & !OutReady.
//   - OutValid stays high in PAYLOAD whenever the buffer head holds a word of this frame; it is guaranteed present because the frame is only started after ReadDone.
//   - Full throughput: one word per cycle when OutReady stays high.
//  Input capture continues in every state. Words for the next event accumulate during emission.
//  Count max = 2**ADDR_WIDTH (256 fits 9 bits); count==0 frames are legal (chk=0).
// TESTING
//  T1: 16 words 16'h0001..16'h0010 then ReadDone, ChipId=8'h05, OutReady=1.
//      -> FFFC,0005,0010,0001..0010,0010 (XOR),FF45; FrameDone once; Busy low after.
//  T2: ReadDone with no data, ChipId=8'hA1 -> FFFC,00A1,0000,0000,FF45.
//  T3: T1 stimulus with OutReady toggling 1/0 each cycle -> identical word sequence.
//      OutData never changes while OutValid & !OutReady.
//  T4: 260 words with ADDR_WIDTH=8, no reads -> Overflow=1, status=16'h8000|ChipId, count=0100, checksum over first 256 stored.
//  T5: event A (4 words) framed; event B (3 words) plus ReadDone during A's payload.
//      -> B frame starts right after A's trailer transfer; two FrameDone pulses.
//      -> Third ReadDone while B pending -> EventLost=1, merged count.
//  T6: Reset asserted mid-PAYLOAD -> next cycle OutValid=0, Busy=0, flags 0.
//      -> A fresh 2-word event frames correctly, with no stale words.

Source files
------------

// File: rtl/asic_event_framer.sv
// Event framer: buffers readout words and emits one framed event per ReadDone
// (header, status, count, payload, XOR checksum, trailer) over valid/ready.
module asic_event_framer #(
    parameter int          ADDR_WIDTH   = 8,
    parameter logic [15:0] HEADER_WORD  = 16'hFFFC,
    parameter logic [15:0] TRAILER_WORD = 16'hFF45
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  ChipId,
    input  logic [15:0] DataIn,
    input  logic        DataInValid,
    input  logic        ReadDone,
    output logic [15:0] OutData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        FrameDone,
    output logic        Overflow,
    output logic        EventLost,
    output logic        Busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HEADER   = 3'd1;
    localparam logic [2:0] S_STATUS   = 3'd2;
    localparam logic [2:0] S_COUNT    = 3'd3;
    localparam logic [2:0] S_PAYLOAD  = 3'd4;
    localparam logic [2:0] S_CHECKSUM = 3'd5;
    localparam logic [2:0] S_TRAILER  = 3'd6;

    logic [15:0]         mem [0:DEPTH-1];
    logic [15:0]         head_reg;
    logic [ADDR_WIDTH:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic                full, empty, wr_en, drop, pop, xfer, take;

    logic [ADDR_WIDTH:0] acc_cnt_reg, cnt_in;
    logic [15:0]         acc_chk_reg, chk_in;
    logic                acc_ovf_reg, ovf_in;

    logic                pend_reg, pend_ovf_reg;
    logic [7:0]          pend_chip_reg;
    logic [ADDR_WIDTH:0] pend_cnt_reg;
    logic [15:0]         pend_chk_reg;

    logic                frm_ovf_reg;
    logic [7:0]          frm_chip_reg;
    logic [ADDR_WIDTH:0] frm_cnt_reg, remain_reg;
    logic [15:0]         frm_chk_reg;

    logic [2:0]          state_reg, state_next;

    // Full/empty come from registered pointers only, so a pop never frees space the same cycle.
    assign full  = (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                   (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign wr_en = DataInValid && !full;
    assign drop  = DataInValid && full;

    assign OutValid    = (state_reg != S_IDLE) && !((state_reg == S_PAYLOAD) && empty);
    assign xfer        = OutValid && OutReady;
    assign pop         = (state_reg == S_PAYLOAD) && xfer;
    assign rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    assign take        = pend_reg && ((state_reg == S_IDLE) || ((state_reg == S_TRAILER) && xfer));
    assign Busy        = (state_reg != S_IDLE);

    // The word stored in the ReadDone cycle still belongs to the closing event.
    assign cnt_in = acc_cnt_reg + (wr_en ? PTR_ONE : '0);
    assign chk_in = acc_chk_reg ^ (wr_en ? DataIn : 16'h0000);
    assign ovf_in = acc_ovf_reg | drop;

    // Read address looks one pop ahead so the head word is ready the cycle after a pop.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= DataIn;
        end
        head_reg <= mem[rd_ptr_next[ADDR_WIDTH-1:0]];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (pend_reg) state_next = S_HEADER;
            S_HEADER:   if (xfer) state_next = S_STATUS;
            S_STATUS:   if (xfer) state_next = S_COUNT;
            S_COUNT:    if (xfer) state_next = (frm_cnt_reg == '0) ? S_CHECKSUM : S_PAYLOAD;
            S_PAYLOAD:  if (xfer && (remain_reg == PTR_ONE)) state_next = S_CHECKSUM;
            S_CHECKSUM: if (xfer) state_next = S_TRAILER;
            S_TRAILER:  if (xfer) state_next = pend_reg ? S_HEADER : S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        OutData = 16'h0000;
        case (state_reg)
            S_HEADER:   OutData = HEADER_WORD;
            S_STATUS:   OutData = {frm_ovf_reg, 7'b0, frm_chip_reg};
            S_COUNT:    OutData = {{(15 - ADDR_WIDTH){1'b0}}, frm_cnt_reg};
            S_PAYLOAD:  OutData = head_reg;
            S_CHECKSUM: OutData = frm_chk_reg;
            S_TRAILER:  OutData = TRAILER_WORD;
            default:    OutData = 16'h0000;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            acc_cnt_reg   <= '0;
            acc_chk_reg   <= '0;
            acc_ovf_reg   <= 1'b0;
            pend_reg      <= 1'b0;
            pend_ovf_reg  <= 1'b0;
            pend_chip_reg <= '0;
            pend_cnt_reg  <= '0;
            pend_chk_reg  <= '0;
            frm_ovf_reg   <= 1'b0;
            frm_chip_reg  <= '0;
            frm_cnt_reg   <= '0;
            frm_chk_reg   <= '0;
            remain_reg    <= '0;
            state_reg     <= S_IDLE;
            FrameDone     <= 1'b0;
            Overflow      <= 1'b0;
            EventLost     <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + (wr_en ? PTR_ONE : '0);
            rd_ptr_reg <= rd_ptr_next;
            Overflow   <= Overflow | drop;
            FrameDone  <= (state_reg == S_TRAILER) && xfer;
            state_reg  <= state_next;

            if (ReadDone) begin
                acc_cnt_reg <= '0;
                acc_chk_reg <= '0;
                acc_ovf_reg <= 1'b0;
            end else begin
                acc_cnt_reg <= cnt_in;
                acc_chk_reg <= chk_in;
                acc_ovf_reg <= ovf_in;
            end

            // A second event arriving before the first is taken merges into it; payloads are contiguous.
            if (ReadDone) begin
                pend_reg      <= 1'b1;
                pend_chip_reg <= ChipId;
                if (pend_reg && !take) begin
                    EventLost    <= 1'b1;
                    pend_cnt_reg <= pend_cnt_reg + cnt_in;
                    pend_chk_reg <= pend_chk_reg ^ chk_in;
                    pend_ovf_reg <= pend_ovf_reg | ovf_in;
                end else begin
                    pend_cnt_reg <= cnt_in;
                    pend_chk_reg <= chk_in;
                    pend_ovf_reg <= ovf_in;
                end
            end else if (take) begin
                pend_reg <= 1'b0;
            end

            if (take) begin
                frm_ovf_reg  <= pend_ovf_reg;
                frm_chip_reg <= pend_chip_reg;
                frm_cnt_reg  <= pend_cnt_reg;
                frm_chk_reg  <= pend_chk_reg;
                remain_reg   <= pend_cnt_reg;
            end else if (pop) begin
                remain_reg <= remain_reg - PTR_ONE;
            end
        end
    end
endmodule
